// File: rtl/condicionador_botoes.sv
// -----------------------------------------------------------------------------
// condicionador_botoes
//
// Conditions two raw, bouncing push buttons (up / down) into clean, stretched
// request pulses for a downstream up/down state machine that runs from a
// divided clock.
//
// Each button goes through a 2-flop synchronizer, is normalized to
// "1 = pressed" and is then debounced. A 0->1 change of a debounced level is
// a press event. A small FSM turns the first press event(s) seen while idle
// into a pulse LARGURA_PULSO cycles long. It then waits until both buttons
// are released before it accepts another press, so there is no queuing and
// no autorepeat.
//
// Parameters
//   ATIVO_BAIXO    1: raw button reads 0 when pressed
//   N_DEBOUNCE     consecutive stable cycles needed to accept a level change
//   LARGURA_PULSO  output pulse length in clock_inicial cycles
//
// Ports
//   clock_inicial  in   board clock, all logic on its rising edge
//   RESET          in   asynchronous, active-low reset
//   BTN_UP         in   raw up button (asynchronous, bouncing)
//   BTN_DOWN       in   raw down button (asynchronous, bouncing)
//   UP             out  registered, stretched up-request pulse
//   DOWN           out  registered, stretched down-request pulse
//   ESTADO         out  current FSM state (debug)
// -----------------------------------------------------------------------------
module condicionador_botoes #(
    parameter int ATIVO_BAIXO   = 1,
    parameter int N_DEBOUNCE    = 1000000,
    parameter int LARGURA_PULSO = 50000000
) (
    input  logic       clock_inicial,
    input  logic       RESET,
    input  logic       BTN_UP,
    input  logic       BTN_DOWN,
    output logic       UP,
    output logic       DOWN,
    output logic [1:0] ESTADO
);

    localparam int W_DEB = $clog2(N_DEBOUNCE + 1);
    localparam int W_PUL = $clog2(LARGURA_PULSO + 1);

    localparam logic [W_DEB-1:0] C_DEB_LAST = W_DEB'(N_DEBOUNCE - 1);
    localparam logic [W_PUL-1:0] C_PUL_LAST = W_PUL'(LARGURA_PULSO - 1);

    // Raw level of a released button; synchronizers reset to it so that the
    // first cycles after reset never look like a press.
    localparam logic C_SOLTO_RAW = (ATIVO_BAIXO != 0);

    typedef enum logic [1:0] {
        OCIOSO        = 2'b00,
        PULSO         = 2'b01,
        ESPERA_SOLTAR = 2'b10
    } estado_t;

    // Bit 0 = up button, bit 1 = down button.
    logic [1:0] w_raw;
    logic [1:0] w_deb;
    logic [1:0] w_evt;

    assign w_raw = {BTN_DOWN, BTN_UP};

    // -------------------------------------------------------------------------
    // Per-button synchronizer, normalization, debounce and press detection
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            logic [1:0]       r_sync;
            logic [W_DEB-1:0] r_cnt;
            logic             r_deb;
            logic             r_deb_d;
            logic             w_norm;

            assign w_norm = (ATIVO_BAIXO != 0) ? ~r_sync[1] : r_sync[1];

            always_ff @(posedge clock_inicial or negedge RESET) begin
                if (!RESET) begin
                    r_sync  <= {2{C_SOLTO_RAW}};
                    r_cnt   <= '0;
                    r_deb   <= 1'b0;
                    r_deb_d <= 1'b0;
                end else begin
                    r_sync  <= {r_sync[0], w_raw[gi]};
                    r_deb_d <= r_deb;
                    if (w_norm == r_deb) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_DEB_LAST) begin
                        // This cycle is the N_DEBOUNCE-th differing one: the
                        // count reaches N_DEBOUNCE, so accept the new level.
                        r_deb <= w_norm;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + W_DEB'(1);
                    end
                end
            end

            assign w_deb[gi] = r_deb;
            // Press only: a release (1->0) never produces an event.
            assign w_evt[gi] = r_deb & ~r_deb_d;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Pulse FSM with registered outputs
    // -------------------------------------------------------------------------
    estado_t          r_estado;
    logic             r_up;
    logic             r_dn;
    logic [W_PUL-1:0] r_cnt_pul;

    always_ff @(posedge clock_inicial or negedge RESET) begin
        if (!RESET) begin
            r_estado  <= OCIOSO;
            r_up      <= 1'b0;
            r_dn      <= 1'b0;
            r_cnt_pul <= '0;
        end else begin
            case (r_estado)
                OCIOSO: begin
                    if (|w_evt) begin
                        // Both events in the same cycle give both outputs
                        // together, so downstream can flag the conflict.
                        r_estado  <= PULSO;
                        r_up      <= w_evt[0];
                        r_dn      <= w_evt[1];
                        r_cnt_pul <= '0;
                    end
                end
                PULSO: begin
                    if (r_cnt_pul == C_PUL_LAST) begin
                        r_up     <= 1'b0;
                        r_dn     <= 1'b0;
                        r_estado <= ESPERA_SOLTAR;
                    end else begin
                        r_cnt_pul <= r_cnt_pul + W_PUL'(1);
                    end
                end
                ESPERA_SOLTAR: begin
                    if (w_deb == 2'b00) begin
                        r_estado <= OCIOSO;
                    end
                end
                default: begin
                    r_estado <= OCIOSO;
                    r_up     <= 1'b0;
                    r_dn     <= 1'b0;
                end
            endcase
        end
    end

    assign UP     = r_up;
    assign DOWN   = r_dn;
    assign ESTADO = r_estado;

endmodule

// File: tb/tb_condicionador_botoes.sv
module tb_condicionador_botoes;

    logic       clk;
    logic       rst_n;
    logic       btn_up;
    logic       btn_dn;
    logic       up;
    logic       dn;
    logic [1:0] estado;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Raw press becomes an output pulse on edge N_DEBOUNCE+3 = 7.
    localparam int LAT = 7;
    localparam int LEN = 8;

    condicionador_botoes #(
        .ATIVO_BAIXO  (1),
        .N_DEBOUNCE   (4),
        .LARGURA_PULSO(8)
    ) dut (
        .clock_inicial(clk),
        .RESET        (rst_n),
        .BTN_UP       (btn_up),
        .BTN_DOWN     (btn_dn),
        .UP           (up),
        .DOWN         (dn),
        .ESTADO       (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // -------------------------------------------------------------------------
    // Scoreboard: expected pulses (rise cycle, length) per output
    // -------------------------------------------------------------------------
    typedef struct {
        int start;
        int len;
    } pulse_t;

    pulse_t q_up[$];
    pulse_t q_dn[$];

    task automatic push_pulse(input bit is_dn, input int start, input int len);
        pulse_t p;
        p.start = start;
        p.len   = len;
        if (is_dn) q_dn.push_back(p);
        else       q_up.push_back(p);
    endtask

    task automatic got_pulse(input bit is_dn, input int start, input int len);
        pulse_t p;
        string  nm;
        nm = is_dn ? "DOWN" : "UP";
        $display("pulse %s start=%0d len=%0d", nm, start, len);
        if ((is_dn && q_dn.size() == 0) || (!is_dn && q_up.size() == 0)) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s_pulse actual=start %0d len %0d required=no pulse", nm, start, len);
        end else begin
            p = is_dn ? q_dn.pop_front() : q_up.pop_front();
            chk({nm, "_start"}, start, p.start);
            chk({nm, "_len"}, len, p.len);
        end
    endtask

    // Monitor samples 2 time units after each rising edge.
    logic up_prev = 1'b0;
    logic dn_prev = 1'b0;
    int   up_start = 0;
    int   dn_start = 0;

    always begin
        @(posedge clk);
        #2;
        if (up && !up_prev) up_start = cyc;
        if (!up && up_prev) got_pulse(1'b0, up_start, cyc - up_start);
        if (dn && !dn_prev) dn_start = cyc;
        if (!dn && dn_prev) got_pulse(1'b1, dn_start, cyc - dn_start);
        up_prev = up;
        dn_prev = dn;
    end

    // -------------------------------------------------------------------------
    // Vector table: inputs applied at a falling edge, outputs checked after
    // n_cyc further falling edges. push_* marks a record whose stimulus
    // starts a press that must produce a pulse.
    // -------------------------------------------------------------------------
    typedef struct {
        logic       b_up;
        logic       b_dn;
        int         n_cyc;
        logic       push_up;
        logic       push_dn;
        logic       e_up;
        logic       e_dn;
        logic [1:0] e_est;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs[NV];

    task automatic check_outs(input string tag, input logic e_up, input logic e_dn, input logic [1:0] e_est);
        $display("%s cyc=%0d UP=%0d DOWN=%0d ESTADO=%0d", tag, cyc, up, dn, estado);
        chk({tag, "_UP"}, int'(up), int'(e_up));
        chk({tag, "_DOWN"}, int'(dn), int'(e_dn));
        chk({tag, "_ESTADO"}, int'(estado), int'(e_est));
    endtask

    initial begin
        // clean press: 30 cycles low, release
        vecs[0]  = '{1'b0, 1'b1,  6, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
        vecs[2]  = '{1'b0, 1'b1,  7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
        vecs[3]  = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[4]  = '{1'b0, 1'b1, 15, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[5]  = '{1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[6]  = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[7]  = '{1'b1, 1'b1,  5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        // simultaneous press
        vecs[8]  = '{1'b0, 1'b0,  7, 1'b1, 1'b1, 1'b1, 1'b1, 2'b01};
        vecs[9]  = '{1'b0, 1'b0,  7, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01};
        vecs[10] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[11] = '{1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[12] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[13] = '{1'b1, 1'b1,  5, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        // lockout: DOWN pressed during the UP pulse is discarded
        vecs[14] = '{1'b0, 1'b1,  7, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01};
        vecs[15] = '{1'b0, 1'b0,  7, 1'b0, 1'b0, 1'b1, 1'b0, 2'b01};
        vecs[16] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[17] = '{1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[18] = '{1'b1, 1'b1,  6, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10};
        vecs[19] = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[20] = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

        // ---- reset with buttons released ----
        rst_n  = 1'b0;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        repeat (3) @(negedge clk);
        check_outs("reset", 1'b0, 1'b0, 2'b00);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_outs("post_reset", 1'b0, 1'b0, 2'b00);

        // ---- table-driven vectors ----
        for (int i = 0; i < NV; i++) begin
            btn_up = vecs[i].b_up;
            btn_dn = vecs[i].b_dn;
            if (vecs[i].push_up) push_pulse(1'b0, cyc + LAT, LEN);
            if (vecs[i].push_dn) push_pulse(1'b1, cyc + LAT, LEN);
            repeat (vecs[i].n_cyc) @(negedge clk);
            check_outs($sformatf("vec%0d", i), vecs[i].e_up, vecs[i].e_dn, vecs[i].e_est);
        end

        // ---- bounce on DOWN: toggle every 2 cycles for 20 cycles ----
        for (int k = 0; k < 10; k++) begin
            btn_dn = (k % 2 == 0) ? 1'b0 : 1'b1;
            repeat (2) @(negedge clk);
        end
        btn_dn = 1'b0;
        push_pulse(1'b1, cyc + LAT, LEN);
        repeat (30) @(negedge clk);
        btn_dn = 1'b1;
        repeat (15) @(negedge clk);
        check_outs("bounce_end", 1'b0, 1'b0, 2'b00);

        // ---- long hold, release, re-press ----
        btn_up = 1'b0;
        push_pulse(1'b0, cyc + LAT, LEN);
        repeat (200) @(negedge clk);
        check_outs("long_hold", 1'b0, 1'b0, 2'b10);
        btn_up = 1'b1;
        repeat (15) @(negedge clk);
        check_outs("hold_release", 1'b0, 1'b0, 2'b00);
        btn_up = 1'b0;
        push_pulse(1'b0, cyc + LAT, LEN);
        repeat (30) @(negedge clk);
        btn_up = 1'b1;
        repeat (15) @(negedge clk);

        // ---- reset in the middle of a pulse, button still held ----
        btn_up = 1'b0;
        push_pulse(1'b0, cyc + LAT, 4);
        repeat (10) @(negedge clk);
        check_outs("pre_reset_pulse", 1'b1, 1'b0, 2'b01);
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 1'b0, 1'b0, 2'b00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Held button must be re-detected after a full debounce.
        push_pulse(1'b0, cyc + LAT, LEN);
        repeat (20) @(negedge clk);
        btn_up = 1'b1;
        repeat (15) @(negedge clk);
        check_outs("final_idle", 1'b0, 1'b0, 2'b00);

        // Every expected pulse must have been observed.
        chk("missing_UP_pulses", q_up.size(), 0);
        chk("missing_DOWN_pulses", q_dn.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
